// File: rtl/axi4_a23_mp_arbiter.sv
// Shares one AXI4 master port between N_MASTERS single-outstanding A23 fetch ports, with independent
// round-robin read/write arbitration. Define AXI4_MP_ARB_LOCK_EN to add exclusive-lock routing.
module axi4_a23_mp_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ID_WIDTH  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [N_MASTERS-1:0]    s_arvalid,
  output logic [N_MASTERS-1:0]    s_arready,
  input  logic [32*N_MASTERS-1:0] s_araddr,
  input  logic [8*N_MASTERS-1:0]  s_arlen,
  output logic [N_MASTERS-1:0]    s_rvalid,
  input  logic [N_MASTERS-1:0]    s_rready,
  output logic [31:0]             s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  input  logic [N_MASTERS-1:0]    s_awvalid,
  output logic [N_MASTERS-1:0]    s_awready,
  input  logic [32*N_MASTERS-1:0] s_awaddr,
  input  logic [N_MASTERS-1:0]    s_wvalid,
  output logic [N_MASTERS-1:0]    s_wready,
  input  logic [32*N_MASTERS-1:0] s_wdata,
  input  logic [4*N_MASTERS-1:0]  s_wstrb,
  input  logic [N_MASTERS-1:0]    s_wlast,
  output logic [N_MASTERS-1:0]    s_bvalid,
  input  logic [N_MASTERS-1:0]    s_bready,
  output logic [1:0]              s_bresp,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [31:0]             m_araddr,
  output logic [7:0]              m_arlen,
  output logic [ID_WIDTH-1:0]     m_arid,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [31:0]             m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [31:0]             m_awaddr,
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [31:0]             m_wdata,
  output logic [3:0]              m_wstrb,
  output logic                    m_wlast,
  input  logic                    m_bvalid,
  output logic                    m_bready,
`ifdef AXI4_MP_ARB_LOCK_EN
  input  logic [N_MASTERS-1:0]    s_arlock,
  input  logic [N_MASTERS-1:0]    s_awlock,
  output logic                    m_arlock,
  output logic                    m_awlock,
`endif
  input  logic [1:0]              m_bresp
);

  localparam int unsigned PW = $clog2(N_MASTERS);

  typedef enum logic [1:0] {StRIdle, StRAddr, StRData} rd_state_e;
  typedef enum logic [1:0] {StWIdle, StWAddr, StWData, StWResp} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic [PW-1:0] rg_q, rg_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wg_q, wg_d, wr_ptr_q, wr_ptr_d;
  logic [N_MASTERS-1:0] aw_req;

  logic [31:0] araddr_a [N_MASTERS];
  logic [7:0]  arlen_a  [N_MASTERS];
  logic [31:0] awaddr_a [N_MASTERS];
  logic [31:0] wdata_a  [N_MASTERS];
  logic [3:0]  wstrb_a  [N_MASTERS];

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
    assign araddr_a[g] = s_araddr[32*g +: 32];
    assign arlen_a[g]  = s_arlen[8*g +: 8];
    assign awaddr_a[g] = s_awaddr[32*g +: 32];
    assign wdata_a[g]  = s_wdata[32*g +: 32];
    assign wstrb_a[g]  = s_wstrb[4*g +: 4];
  end

  // First requester at or after ptr, wrapping modulo N_MASTERS.
  function automatic logic [PW-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                            input logic [PW-1:0] ptr);
    logic [PW-1:0] pick;
    logic          found;
    int unsigned   idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      idx = (32'(ptr) + i) % N_MASTERS;
      if (!found && req[PW'(idx)]) begin
        pick  = PW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == N_MASTERS - 1) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_state_d = rd_state_q;
    rg_d       = rg_q;
    rd_ptr_d   = rd_ptr_q;
    m_arvalid  = 1'b0;
    m_araddr   = '0;
    m_arlen    = '0;
    m_arid     = '0;
    s_arready  = '0;
    s_rvalid   = '0;
    m_rready   = 1'b0;
    s_rdata    = '0;
    s_rresp    = '0;
    s_rlast    = 1'b0;
    unique case (rd_state_q)
      StRIdle: begin
        if (|s_arvalid) begin
          rg_d       = rr_pick(s_arvalid, rd_ptr_q);
          rd_state_d = StRAddr;
        end
      end
      StRAddr: begin
        m_arvalid       = 1'b1;
        m_araddr        = araddr_a[rg_q];
        m_arlen         = arlen_a[rg_q];
        m_arid          = ID_WIDTH'(rg_q);
        s_arready[rg_q] = m_arready;
        if (m_arready) rd_state_d = StRData;
      end
      StRData: begin
        s_rvalid[rg_q] = m_rvalid;
        m_rready       = s_rready[rg_q];
        if (m_rvalid) begin
          s_rdata = m_rdata;
          s_rresp = m_rresp;
          s_rlast = m_rlast;
        end
        if (m_rvalid && m_rready && m_rlast) begin
          rd_state_d = StRIdle;
          rd_ptr_d   = ptr_inc(rg_q);
        end
      end
      default: rd_state_d = StRIdle;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wg_d       = wg_q;
    wr_ptr_d   = wr_ptr_q;
    m_awvalid  = 1'b0;
    m_awaddr   = '0;
    m_awid     = '0;
    s_awready  = '0;
    m_wvalid   = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_wlast    = 1'b0;
    s_wready   = '0;
    s_bvalid   = '0;
    s_bresp    = '0;
    m_bready   = 1'b0;
    unique case (wr_state_q)
      StWIdle: begin
        if (|aw_req) begin
          wg_d       = rr_pick(aw_req, wr_ptr_q);
          wr_state_d = StWAddr;
        end
      end
      StWAddr: begin
        m_awvalid       = 1'b1;
        m_awaddr        = awaddr_a[wg_q];
        m_awid          = ID_WIDTH'(wg_q);
        s_awready[wg_q] = m_awready;
        if (m_awready) wr_state_d = StWData;
      end
      StWData: begin
        m_wvalid       = s_wvalid[wg_q];
        s_wready[wg_q] = m_wready;
        if (m_wvalid) begin
          m_wdata = wdata_a[wg_q];
          m_wstrb = wstrb_a[wg_q];
          m_wlast = s_wlast[wg_q];
        end
        if (m_wvalid && m_wready && m_wlast) wr_state_d = StWResp;
      end
      StWResp: begin
        s_bvalid[wg_q] = m_bvalid;
        m_bready       = s_bready[wg_q];
        if (m_bvalid) s_bresp = m_bresp;
        if (m_bvalid && m_bready) begin
          wr_state_d = StWIdle;
          wr_ptr_d   = ptr_inc(wg_q);
        end
      end
      default: wr_state_d = StWIdle;
    endcase
  end

`ifdef AXI4_MP_ARB_LOCK_EN
  logic          excl_vld_q, excl_vld_d;
  logic [PW-1:0] excl_own_q, excl_own_d;

  always_comb begin
    excl_vld_d = excl_vld_q;
    excl_own_d = excl_own_q;
    if (m_bready && m_bvalid && excl_vld_q && (wg_q == excl_own_q)) excl_vld_d = 1'b0;
    // A lock taken in the same cycle as a release must win.
    if (m_arvalid && m_arready) begin
      if (s_arlock[rg_q]) begin
        excl_vld_d = 1'b1;
        excl_own_d = rg_q;
      end else if (excl_vld_q && (rg_q == excl_own_q)) begin
        excl_vld_d = 1'b0;
      end
    end
  end

  assign aw_req   = excl_vld_q ? (s_awvalid & (N_MASTERS'(1) << excl_own_q)) : s_awvalid;
  assign m_arlock = m_arvalid & s_arlock[rg_q];
  assign m_awlock = m_awvalid & s_awlock[wg_q];

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      excl_vld_q <= 1'b0;
      excl_own_q <= '0;
    end else begin
      excl_vld_q <= excl_vld_d;
      excl_own_q <= excl_own_d;
    end
  end
`else
  assign aw_req = s_awvalid;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rd_state_q <= StRIdle;
      wr_state_q <= StWIdle;
      rg_q       <= '0;
      wg_q       <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rg_q       <= rg_d;
      wg_q       <= wg_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

endmodule

// File: tb/tb_axi4_a23_mp_arbiter.sv
// Bench for axi4_a23_mp_arbiter: random requests checked against a round-robin arbitration model.
module tb_axi4_a23_mp_arbiter;
  localparam int N   = 3;
  localparam int IW  = 4;
  localparam int PWT = $clog2(N);

  logic i_clk = 1'b0;
  logic i_rstn = 1'b0;
  logic [N-1:0] s_arvalid = '0, s_arready, s_rvalid, s_rready = '0;
  logic [32*N-1:0] s_araddr = '0, s_awaddr = '0, s_wdata = '0;
  logic [8*N-1:0] s_arlen = '0;
  logic [31:0] s_rdata;
  logic [1:0] s_rresp, s_bresp;
  logic s_rlast;
  logic [N-1:0] s_awvalid = '0, s_awready, s_wvalid = '0, s_wready, s_wlast = '0;
  logic [4*N-1:0] s_wstrb = '0;
  logic [N-1:0] s_bvalid, s_bready = '0;
  logic m_arvalid, m_arready = 1'b0, m_rvalid = 1'b0, m_rready, m_rlast = 1'b0;
  logic [31:0] m_araddr, m_rdata = '0, m_awaddr, m_wdata;
  logic [7:0] m_arlen;
  logic [IW-1:0] m_arid, m_awid;
  logic [1:0] m_rresp = '0, m_bresp = '0;
  logic m_awvalid, m_awready = 1'b0, m_wvalid, m_wready = 1'b0, m_wlast;
  logic [3:0] m_wstrb;
  logic m_bvalid = 1'b0, m_bready;
`ifdef AXI4_MP_ARB_LOCK_EN
  logic [N-1:0] s_arlock = '0, s_awlock = '0;
  logic m_arlock, m_awlock;
`endif

  int checks = 0;
  int failures = 0;
  int rd_ptr_m = 0;
  int wr_ptr_m = 0;

  always #5 i_clk = ~i_clk;

  axi4_a23_mp_arbiter #(.N_MASTERS(N), .ID_WIDTH(IW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arid(m_arid), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awaddr(m_awaddr), .m_awid(m_awid), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_bvalid(m_bvalid),
    .m_bready(m_bready),
`ifdef AXI4_MP_ARB_LOCK_EN
    .s_arlock(s_arlock), .s_awlock(s_awlock), .m_arlock(m_arlock), .m_awlock(m_awlock),
`endif
    .m_bresp(m_bresp)
  );

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int rr_model(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) if (req[PWT'((ptr + k) % N)]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic any_out();
    logic r;
    r = |{m_arvalid, m_araddr, m_arlen, m_arid, s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
          m_rready, m_awvalid, m_awaddr, m_awid, s_awready, s_wready, m_wvalid, m_wdata, m_wstrb,
          m_wlast, s_bvalid, s_bresp, m_bready};
`ifdef AXI4_MP_ARB_LOCK_EN
    r = r | m_arlock | m_awlock;
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_rready = '0;
    s_awvalid = '0; s_awaddr = '0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0;
    s_bready = '0; m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
`ifdef AXI4_MP_ARB_LOCK_EN
    s_arlock = '0; s_awlock = '0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rstn = 1'b0;
    step();
    step();
    i_rstn = 1'b1;
    rd_ptr_m = 0;
    wr_ptr_m = 0;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    s_arvalid = '1; s_awvalid = '1; m_rvalid = 1; m_rdata = $urandom; m_bvalid = 1; m_bresp = 2'd3;
    step();
    step();
    checks++;
    if (any_out() !== 1'b0) $display("FAIL reset_outputs got nonzero output, want all zero");
    if (any_out() !== 1'b0) failures++;
    do_reset();
  endtask

  task automatic test_concurrent();
    do_reset();
    s_arvalid = 3'b001; s_araddr[31:0] = 32'h1000; s_arlen[7:0] = 8'd0;
    s_awvalid = 3'b010; s_awaddr[63:32] = 32'h2000;
    #1; checks++;
    if (m_arvalid !== 1'b0 || m_awvalid !== 1'b0) begin
      failures++; $display("FAIL grant_latency arvalid=%b awvalid=%b want 0 0", m_arvalid, m_awvalid);
    end
    step(); checks++;
    if (m_arvalid !== 1 || m_araddr !== 32'h1000 || m_arid !== 4'd0 || m_awvalid !== 1 ||
        m_awaddr !== 32'h2000 || m_awid !== 4'd1) begin
      failures++;
      $display("FAIL conc_addr ar=%b/%h/%0d aw=%b/%h/%0d want 1/1000/0 1/2000/1",
               m_arvalid, m_araddr, m_arid, m_awvalid, m_awaddr, m_awid);
    end
    m_arready = 1; m_awready = 1; #1; checks++;
    if (s_arready !== 3'b001 || s_awready !== 3'b010) begin
      failures++; $display("FAIL conc_ready arready=%b awready=%b want 001 010", s_arready, s_awready);
    end
    step();
    s_arvalid = '0; s_awvalid = '0; m_arready = 0; m_awready = 0;
    s_wvalid = 3'b010; s_wdata[63:32] = 32'hDEADBEEF; s_wstrb[7:4] = 4'hF; s_wlast = 3'b010;
    m_wready = 1; m_rvalid = 1; m_rdata = 32'hCAFEF00D; m_rlast = 1; s_rready = '1;
    #1; checks++;
    if (m_wvalid !== 1 || m_wdata !== 32'hDEADBEEF || m_wstrb !== 4'hF || m_wlast !== 1 ||
        s_wready !== 3'b010 || s_rvalid !== 3'b001 || s_rdata !== 32'hCAFEF00D || s_rlast !== 1) begin
      failures++;
      $display("FAIL conc_data w=%b/%h/%h/%b wready=%b rvalid=%b rdata=%h want 1/deadbeef/f/1 010 001 cafef00d",
               m_wvalid, m_wdata, m_wstrb, m_wlast, s_wready, s_rvalid, s_rdata);
    end
    step();
    idle_inputs();
    m_bvalid = 1; m_bresp = 2'd0; s_bready = '1; #1; checks++;
    if (s_bvalid !== 3'b010 || s_bresp !== 2'd0 || m_bready !== 1) begin
      failures++; $display("FAIL conc_b bvalid=%b bresp=%0d want 010 0", s_bvalid, s_bresp);
    end
    step();
    idle_inputs(); #1; checks++;
    if (any_out() !== 1'b0) begin
      failures++; $display("FAIL conc_idle got nonzero output, want all zero");
    end
    rd_ptr_m = 1;
    wr_ptr_m = 2;
  endtask

  task automatic test_rr_read(input int iters, input logic [N-1:0] allow);
    logic [N-1:0] pend;
    logic [31:0] addr [N];
    logic [7:0] len [N];
    logic [31:0] d;
    logic [1:0] rr;
    logic lst;
    int exp, stall;
    pend = '0;
    for (int it = 0; it < iters; it++) begin
      logic [N-1:0] nw;
      nw = N'($urandom_range(0, (1 << N) - 1)) & ~pend & allow;
      if ((pend | nw) == '0) nw = allow;
      for (int k = 0; k < N; k++) if (nw[k]) begin
        addr[k] = $urandom; len[k] = 8'($urandom_range(0, 3));
        s_araddr[32*k +: 32] = addr[k]; s_arlen[8*k +: 8] = len[k];
      end
      pend |= nw; s_arvalid = pend;
      #1; checks++;
      if (m_arvalid !== 1'b0) begin
        failures++; $display("FAIL rd_idle_gap it=%0d arvalid=%b want 0", it, m_arvalid);
      end
      step();
      exp = rr_model(pend, rd_ptr_m);
      checks++;
      if (m_arvalid !== 1 || m_arid !== IW'(exp) || m_araddr !== addr[exp] || m_arlen !== len[exp]) begin
        failures++;
        $display("FAIL rd_grant it=%0d got id=%0d addr=%h len=%0d want id=%0d addr=%h len=%0d",
                 it, m_arid, m_araddr, m_arlen, exp, addr[exp], len[exp]);
      end
      stall = (it == 0) ? 10 : $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        step(); checks++;
        if (s_arready !== '0 || m_arvalid !== 1 || m_araddr !== addr[exp] || m_arid !== IW'(exp)) begin
          failures++;
          $display("FAIL rd_stall it=%0d arready=%b addr=%h id=%0d want 000 %h %0d",
                   it, s_arready, m_araddr, m_arid, addr[exp], exp);
        end
      end
      m_arready = 1; #1; checks++;
      if (s_arready !== (N'(1) << exp)) begin
        failures++; $display("FAIL rd_arready it=%0d got %b want %b", it, s_arready, N'(1) << exp);
      end
      step();
      m_arready = 0; pend[exp] = 1'b0; s_arvalid = pend;
      for (int b = 0; b <= int'(len[exp]); b++) begin
        d = $urandom; rr = 2'($urandom); lst = (b == int'(len[exp]));
        m_rvalid = 1; m_rdata = d; m_rresp = rr; m_rlast = lst; s_rready = N'($urandom);
        for (int t = 0; t < 2; t++) begin
          if (t == 1) s_rready = '1;
          #1; checks++;
          if (s_rvalid !== (N'(1) << exp) || s_rdata !== d || s_rresp !== rr || s_rlast !== lst ||
              m_rready !== s_rready[exp]) begin
            failures++;
            $display("FAIL rd_beat it=%0d rvalid=%b data=%h last=%b rready=%b want %b %h %b %b",
                     it, s_rvalid, s_rdata, s_rlast, m_rready, N'(1) << exp, d, lst, s_rready[exp]);
          end
          step();
          if (s_rready[exp]) break;
        end
      end
      m_rvalid = 0; m_rlast = 0; m_rdata = '0; m_rresp = '0; s_rready = '0;
      rd_ptr_m = (exp + 1) % N;
    end
    s_arvalid = '0;
  endtask

  task automatic test_rr_write(input int iters);
    logic [N-1:0] pend, exp_wr;
    logic [31:0] addr [N];
    int nb [N];
    logic [31:0] d;
    logic [3:0] st;
    logic [1:0] br;
    logic wl;
    int exp;
    pend = '0;
    for (int it = 0; it < iters; it++) begin
      logic [N-1:0] nw;
      nw = N'($urandom_range(0, (1 << N) - 1)) & ~pend;
      if ((pend | nw) == '0) nw = N'(1) << $urandom_range(0, N - 1);
      for (int k = 0; k < N; k++) if (nw[k]) begin
        addr[k] = $urandom; nb[k] = $urandom_range(1, 3); s_awaddr[32*k +: 32] = addr[k];
      end
      pend |= nw; s_awvalid = pend;
      step();
      exp = rr_model(pend, wr_ptr_m);
      checks++;
      if (m_awvalid !== 1 || m_awid !== IW'(exp) || m_awaddr !== addr[exp]) begin
        failures++;
        $display("FAIL wr_grant it=%0d got v=%b id=%0d addr=%h want 1 %0d %h",
                 it, m_awvalid, m_awid, m_awaddr, exp, addr[exp]);
      end
      m_awready = 1; #1; checks++;
      if (s_awready !== (N'(1) << exp)) begin
        failures++; $display("FAIL wr_awready it=%0d got %b want %b", it, s_awready, N'(1) << exp);
      end
      step();
      m_awready = 0; pend[exp] = 1'b0; s_awvalid = pend;
      for (int b = 0; b < nb[exp]; b++) begin
        d = $urandom; st = 4'($urandom); wl = (b == nb[exp] - 1);
        for (int k = 0; k < N; k++) s_wdata[32*k +: 32] = $urandom;
        s_wstrb = (4*N)'($urandom);
        s_wdata[32*exp +: 32] = d; s_wstrb[4*exp +: 4] = st;
        s_wlast = N'(wl) << exp; s_wvalid = N'(1) << exp; m_wready = 1'($urandom);
        exp_wr = m_wready ? (N'(1) << exp) : '0;
        #1; checks++;
        if (m_wvalid !== 1 || m_wdata !== d || m_wstrb !== st || m_wlast !== wl || s_wready !== exp_wr) begin
          failures++;
          $display("FAIL wr_beat it=%0d got %b %h %h %b wready=%b want 1 %h %h %b %b",
                   it, m_wvalid, m_wdata, m_wstrb, m_wlast, s_wready, d, st, wl, exp_wr);
        end
        if (!m_wready) begin
          step();
          m_wready = 1;
        end
        step();
      end
      s_wvalid = '0; s_wlast = '0; m_wready = 0;
      #1; checks++;
      if (m_wvalid !== 0 || m_wdata !== '0 || m_wstrb !== '0 || s_wready !== '0) begin
        failures++; $display("FAIL wr_resp_quiet it=%0d wvalid=%b wdata=%h wready=%b want 0 0 000",
                             it, m_wvalid, m_wdata, s_wready);
      end
      br = 2'($urandom); m_bvalid = 1; m_bresp = br; s_bready = N'($urandom) | (N'(1) << exp);
      #1; checks++;
      if (s_bvalid !== (N'(1) << exp) || s_bresp !== br || m_bready !== 1) begin
        failures++; $display("FAIL wr_b it=%0d bvalid=%b bresp=%0d bready=%b want %b %0d 1",
                             it, s_bvalid, s_bresp, m_bready, N'(1) << exp, br);
      end
      step();
      m_bvalid = 0; m_bresp = '0; s_bready = '0;
      wr_ptr_m = (exp + 1) % N;
    end
    s_awvalid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_arvalid = 3'b010; step(); m_arready = 1; step(); m_arready = 0; s_arvalid = '0;
    m_rvalid = 1; m_rlast = 1; s_rready = '1; step(); m_rvalid = 0; m_rlast = 0;
    s_arvalid = 3'b100; step(); m_arready = 1; step(); m_arready = 0; s_arvalid = '0;
    m_rvalid = 1; m_rdata = 32'h1234_5678; m_rlast = 1; s_rready = '0;
    #1; checks++;
    if (s_rvalid !== 3'b100) begin
      failures++; $display("FAIL rst_mid_setup rvalid=%b want 100", s_rvalid);
    end
    i_rstn = 1'b0;
    step(); checks++;
    if (any_out() !== 1'b0) begin
      failures++; $display("FAIL rst_mid_outputs got nonzero output, want all zero");
    end
    i_rstn = 1'b1; idle_inputs();
    rd_ptr_m = 0; wr_ptr_m = 0;
    s_arvalid = 3'b110; s_awvalid = 3'b101;
    step(); checks++;
    if (m_arid !== IW'(rr_model(3'b110, rd_ptr_m)) || m_awid !== IW'(rr_model(3'b101, wr_ptr_m))) begin
      failures++; $display("FAIL rst_mid_ptrs arid=%0d awid=%0d want 1 0", m_arid, m_awid);
    end
    do_reset();
  endtask

`ifdef AXI4_MP_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    s_arvalid = 3'b010; s_arlock = 3'b010; s_araddr[63:32] = 32'h3000;
    step(); checks++;
    if (m_arvalid !== 1 || m_arid !== 4'd1 || m_arlock !== 1) begin
      failures++; $display("FAIL lock_ar v=%b id=%0d lock=%b want 1 1 1", m_arvalid, m_arid, m_arlock);
    end
    m_arready = 1; step(); m_arready = 0; s_arvalid = '0; s_arlock = '0;
    m_rvalid = 1; m_rlast = 1; s_rready = '1; step(); m_rvalid = 0; m_rlast = 0;
    s_awvalid = 3'b011;
    step(); checks++;
    if (m_awvalid !== 1 || m_awid !== 4'd1) begin
      failures++; $display("FAIL lock_aw_grant v=%b id=%0d want 1 1", m_awvalid, m_awid);
    end
    m_awready = 1; step(); m_awready = 0; s_awvalid = 3'b001;
    s_wvalid = 3'b010; s_wlast = 3'b010; m_wready = 1; step();
    s_wvalid = '0; s_wlast = '0; m_wready = 0;
    m_bvalid = 1; s_bready = '1; step(); m_bvalid = 0;
    step(); checks++;
    if (m_awvalid !== 1 || m_awid !== 4'd0) begin
      failures++; $display("FAIL lock_release v=%b id=%0d want 1 0", m_awvalid, m_awid);
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_concurrent();
    test_rr_read(40, '1);
    test_rr_read(4, 3'b100);
    test_rr_write(30);
    test_reset_mid();
`ifdef AXI4_MP_ARB_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
